// File: rtl/data_bus_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package data_bus_pkg;

  // Identifies which master issued a transaction.
  typedef logic master_id_t;

  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  // Arbitration policy selectors for PRIO_MODE.
  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/resp_id_fifo.sv
// In-order FIFO of master IDs for accepted transactions still awaiting rvalid.
module resp_id_fifo
  import data_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  logic       pop,
  input  master_id_t push_id,
  output master_id_t head_id,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  master_id_t       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rptr];

  // Storage: written only on an accepted push, never reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= push_id;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave req/gnt/rvalid arbiter with in-order response routing.
//
// Handshake: a master holds req and its address phase stable until it sees
// gnt in the same cycle; the transfer is accepted on the cycle where
// slv_req_o & slv_gnt_i. Exactly one rvalid per accepted transfer comes back
// in issue order, at least one cycle after acceptance.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                m0_req_i,
  output logic                m0_gnt_o,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_be_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  output logic                m1_gnt_o,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_be_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                slv_req_o,
  input  logic                slv_gnt_i,
  output logic [ADDR_W-1:0]   slv_addr_o,
  output logic                slv_we_o,
  output logic [DATA_W/8-1:0] slv_be_o,
  output logic [DATA_W-1:0]   slv_wdata_o,
  input  logic                slv_rvalid_i,
  input  logic [DATA_W-1:0]   slv_rdata_i,
  output logic                err_o
);

  master_id_t winner;
  master_id_t last_grant;
  master_id_t lock_id;
  logic       lock_valid;
  logic       win_req;
  logic       accept;
  logic       fifo_full;
  logic       fifo_empty;
  master_id_t head_id;
  logic       rsp_valid;

  // Winner: a stalled address phase stays locked, otherwise policy decides.
  always_comb begin
    winner = M0;
    if (lock_valid) begin
      winner = lock_id;
    end else if (m1_req_i && !m0_req_i) begin
      winner = M1;
    end else if (m0_req_i && m1_req_i) begin
      winner = (PRIO_MODE == PRIO_FIXED) ? M0 : ~last_grant;
    end
  end

  // Without a lock the winner is always a requester, so this equals
  // m0_req|m1_req; under a lock it follows the locked master's req.
  assign win_req   = (winner == M1) ? m1_req_i : m0_req_i;
  assign slv_req_o = win_req & ~fifo_full;
  assign accept    = slv_req_o & slv_gnt_i;
  assign m0_gnt_o  = accept & (winner == M0);
  assign m1_gnt_o  = accept & (winner == M1);

  // Address-phase mux; driven to zero while nothing is presented.
  always_comb begin
    slv_addr_o  = '0;
    slv_we_o    = 1'b0;
    slv_be_o    = '0;
    slv_wdata_o = '0;
    if (slv_req_o) begin
      if (winner == M1) begin
        slv_addr_o  = m1_addr_i;
        slv_we_o    = m1_we_i;
        slv_be_o    = m1_be_i;
        slv_wdata_o = m1_wdata_i;
      end else begin
        slv_addr_o  = m0_addr_i;
        slv_we_o    = m0_we_i;
        slv_be_o    = m0_be_i;
        slv_wdata_o = m0_wdata_i;
      end
    end
  end

  // Response routing: only the head master sees rvalid; data fans out to both.
  assign rsp_valid   = slv_rvalid_i & ~fifo_empty;
  assign m0_rvalid_o = rsp_valid & (head_id == M0);
  assign m1_rvalid_o = rsp_valid & (head_id == M1);
  assign m0_rdata_o  = slv_rdata_i;
  assign m1_rdata_o  = slv_rdata_i;

  // Lock, round-robin history and sticky spurious-rvalid error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_valid <= 1'b0;
      lock_id    <= M0;
      last_grant <= M1;
      err_o      <= 1'b0;
    end else begin
      if (slv_req_o && !slv_gnt_i) begin
        lock_valid <= 1'b1;
        lock_id    <= winner;
      end else begin
        lock_valid <= 1'b0;
      end
      if (accept) last_grant <= winner;
      if (slv_rvalid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  resp_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_resp_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (accept),
    .pop     (rsp_valid),
    .push_id (winner),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed table-driven bench for data_bus_arbiter: a round-robin instance (a)
// and a fixed-priority instance (b) share the same stimulus.
module tb_data_bus_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0040;
  localparam logic [31:0] B0 = 32'h0000_0100;
  localparam logic [31:0] B1 = 32'h0000_0200;
  localparam logic        M0_WE = 1'b0;
  localparam logic [3:0]  M0_BE = 4'hF;
  localparam logic [31:0] M0_WD = 32'hAAAA_0000;
  localparam logic        M1_WE = 1'b1;
  localparam logic [3:0]  M1_BE = 4'h3;
  localparam logic [31:0] M1_WD = 32'h5555_1111;

  typedef struct {
    logic        rst_n;
    logic        r0, r1;
    logic [31:0] a0, a1;
    logic        g, rv;
    logic [31:0] rd;
    logic        e_g0, e_g1;
    logic [1:0]  e_win;   // 0: nothing presented, 1: m0, 2: m1
    logic        e_rv0, e_rv1, e_err;
    logic        eb_g0, eb_g1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = '0, m1_be = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        slv_gnt = 1'b0, slv_rvalid = 1'b0;
  logic [31:0] slv_rdata = '0;

  logic        a_m0_gnt, a_m1_gnt, a_m0_rv, a_m1_rv, a_slv_req, a_slv_we, a_err;
  logic [31:0] a_m0_rd, a_m1_rd, a_slv_addr, a_slv_wdata;
  logic [3:0]  a_slv_be;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rv, b_m1_rv, b_slv_req, b_slv_we, b_err;
  logic [31:0] b_m0_rd, b_m1_rd, b_slv_addr, b_slv_wdata;
  logic [3:0]  b_slv_be;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  vec_t vq[$];

  // Clock and DUTs.
  always #5 clk = ~clk;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .PRIO_MODE(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(a_m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(a_m0_rv), .m0_rdata_o(a_m0_rd),
    .m1_req_i(m1_req), .m1_gnt_o(a_m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(a_m1_rv), .m1_rdata_o(a_m1_rd),
    .slv_req_o(a_slv_req), .slv_gnt_i(slv_gnt), .slv_addr_o(a_slv_addr), .slv_we_o(a_slv_we),
    .slv_be_o(a_slv_be), .slv_wdata_o(a_slv_wdata), .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i(slv_rdata), .err_o(a_err)
  );

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTST(2), .PRIO_MODE(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(b_m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(b_m0_rv), .m0_rdata_o(b_m0_rd),
    .m1_req_i(m1_req), .m1_gnt_o(b_m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(b_m1_rv), .m1_rdata_o(b_m1_rd),
    .slv_req_o(b_slv_req), .slv_gnt_i(slv_gnt), .slv_addr_o(b_slv_addr), .slv_we_o(b_slv_we),
    .slv_be_o(b_slv_be), .slv_wdata_o(b_slv_wdata), .slv_rvalid_i(slv_rvalid),
    .slv_rdata_i(slv_rdata), .err_o(b_err)
  );

  function automatic vec_t mk(
    input logic rst_n_v, r0, r1, input logic [31:0] a0, a1,
    input logic g, rv, input logic [31:0] rd,
    input logic e_g0, e_g1, input logic [1:0] e_win,
    input logic e_rv0, e_rv1, e_err, eb_g0, eb_g1);
    vec_t v;
    v.rst_n = rst_n_v; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1;
    v.g = g; v.rv = rv; v.rd = rd;
    v.e_g0 = e_g0; v.e_g1 = e_g1; v.e_win = e_win;
    v.e_rv0 = e_rv0; v.e_rv1 = e_rv1; v.e_err = e_err;
    v.eb_g0 = eb_g0; v.eb_g1 = eb_g1;
    return v;
  endfunction

  // Scoreboard compare.
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual=%h required=%h", nm, cur, act, exp);
    end
  endtask

  // Driver: one cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic rst_n_v, r0, r1, input logic [31:0] a0, a1,
                       input logic g, rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    rst_n = rst_n_v; m0_req = r0; m1_req = r1; m0_addr = a0; m1_addr = a1;
    slv_gnt = g; slv_rvalid = rv; slv_rdata = rd;
    #3;
  endtask

  task automatic check_vec(input vec_t v);
    logic [31:0] x_addr, x_wd;
    logic        x_we;
    logic [3:0]  x_be;
    x_addr = '0; x_we = 1'b0; x_be = '0; x_wd = '0;
    if (v.e_win == 2'd1) begin
      x_addr = v.a0; x_we = M0_WE; x_be = M0_BE; x_wd = M0_WD;
    end else if (v.e_win == 2'd2) begin
      x_addr = v.a1; x_we = M1_WE; x_be = M1_BE; x_wd = M1_WD;
    end
    check("a_m0_gnt", 32'(a_m0_gnt), 32'(v.e_g0));
    check("a_m1_gnt", 32'(a_m1_gnt), 32'(v.e_g1));
    check("a_slv_req", 32'(a_slv_req), 32'(v.e_win != 2'd0));
    check("a_slv_addr", a_slv_addr, x_addr);
    check("a_slv_we", 32'(a_slv_we), 32'(x_we));
    check("a_slv_be", 32'(a_slv_be), 32'(x_be));
    check("a_slv_wdata", a_slv_wdata, x_wd);
    check("a_m0_rvalid", 32'(a_m0_rv), 32'(v.e_rv0));
    check("a_m1_rvalid", 32'(a_m1_rv), 32'(v.e_rv1));
    check("a_err", 32'(a_err), 32'(v.e_err));
    if (v.e_rv0) check("a_m0_rdata", a_m0_rd, v.rd);
    if (v.e_rv1) check("a_m1_rdata", a_m1_rd, v.rd);
    check("b_m0_gnt", 32'(b_m0_gnt), 32'(v.eb_g0));
    check("b_m1_gnt", 32'(b_m1_gnt), 32'(v.eb_g1));
  endtask

  initial begin
    m0_we = M0_WE; m0_be = M0_BE; m0_wdata = M0_WD;
    m1_we = M1_WE; m1_be = M1_BE; m1_wdata = M1_WD;

    // Reset state and single m0 read with one-cycle response.
    vq.push_back(mk(0,0,0,A0,A1,0,0,32'h0,          0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,A0,A1,0,0,32'h0,          0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,A0,A1,1,0,32'h0,          1,0,1,0,0,0,1,0));
    vq.push_back(mk(1,0,0,A0,A1,1,1,32'hDEADBEEF,   0,0,0,1,0,0,0,0));
    // Both masters request continuously: RR alternates, fixed keeps m0.
    vq.push_back(mk(0,0,0,B0,B1,0,0,32'h0,          0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,1,B0,B1,1,0,32'h0,          1,0,1,0,0,0,1,0));
    vq.push_back(mk(1,1,1,B0,B1,1,1,32'h1111_0001,  0,1,2,1,0,0,1,0));
    vq.push_back(mk(1,1,1,B0,B1,1,1,32'h1111_0002,  1,0,1,0,1,0,1,0));
    vq.push_back(mk(1,1,1,B0,B1,1,1,32'h1111_0003,  0,1,2,1,0,0,1,0));
    vq.push_back(mk(1,0,0,B0,B1,1,1,32'h1111_0004,  0,0,0,0,1,0,0,0));
    // Slave stall holds m1's address phase while m0 joins.
    vq.push_back(mk(0,0,0,A0,A1,0,0,32'h0,          0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,0,1,A0,A1,0,0,32'h0,          0,0,2,0,0,0,0,0));
    vq.push_back(mk(1,1,1,A0,A1,0,0,32'h0,          0,0,2,0,0,0,0,0));
    vq.push_back(mk(1,1,1,A0,A1,0,0,32'h0,          0,0,2,0,0,0,0,0));
    vq.push_back(mk(1,1,1,A0,A1,1,0,32'h0,          0,1,2,0,0,0,0,1));
    vq.push_back(mk(1,1,0,A0,A1,1,0,32'h0,          1,0,1,0,0,0,1,0));
    vq.push_back(mk(1,0,0,A0,A1,0,1,32'h2222_0001,  0,0,0,0,1,0,0,0));
    vq.push_back(mk(1,0,0,A0,A1,0,1,32'h2222_0002,  0,0,0,1,0,0,0,0));
    // Outstanding limit of two: third request waits for the first pop.
    vq.push_back(mk(0,0,0,A0,A1,0,0,32'h0,          0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,A0,A1,1,0,32'h0,          1,0,1,0,0,0,1,0));
    vq.push_back(mk(1,0,1,A0,A1,1,0,32'h0,          0,1,2,0,0,0,0,1));
    vq.push_back(mk(1,1,0,A0,A1,1,0,32'h0,          0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,0,A0,A1,1,1,32'h3333_0001,  0,0,0,1,0,0,0,0));
    vq.push_back(mk(1,1,0,A0,A1,1,1,32'h3333_0002,  1,0,1,0,1,0,1,0));
    vq.push_back(mk(1,0,0,A0,A1,0,1,32'h3333_0003,  0,0,0,1,0,0,0,0));
    // Spurious rvalid sets a sticky error; reset clears it and the FIFO.
    vq.push_back(mk(1,0,0,A0,A1,0,1,32'h4444_0001,  0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,0,0,A0,A1,0,0,32'h0,          0,0,0,0,0,1,0,0));
    vq.push_back(mk(1,0,0,A0,A1,0,0,32'h0,          0,0,0,0,0,1,0,0));
    vq.push_back(mk(1,0,1,A0,A1,1,0,32'h0,          0,1,2,0,0,1,0,1));
    vq.push_back(mk(0,0,0,A0,A1,0,0,32'h0,          0,0,0,0,0,0,0,0));
    vq.push_back(mk(1,1,1,A0,A1,1,0,32'h0,          1,0,1,0,0,0,1,0));
    vq.push_back(mk(1,0,0,A0,A1,0,1,32'h4444_0002,  0,0,0,1,0,0,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      cur = i;
      drive(vq[i].rst_n, vq[i].r0, vq[i].r1, vq[i].a0, vq[i].a1,
            vq[i].g, vq[i].rv, vq[i].rd);
      if (vq[i].rst_n) check_vec(vq[i]);
    end

    // Locked master withdraws its request: nothing is presented that cycle,
    // and the other master is served once the lock has lapsed.
    cur = 100;
    drive(1'b0, 1'b0, 1'b0, A0, A1, 1'b0, 1'b0, 32'h0);
    cur = 101;
    drive(1'b1, 1'b0, 1'b1, A0, A1, 1'b0, 1'b0, 32'h0);
    check("lock_req", 32'(a_slv_req), 32'd1);
    check("lock_addr", a_slv_addr, A1);
    cur = 102;
    drive(1'b1, 1'b1, 1'b0, A0, A1, 1'b0, 1'b0, 32'h0);
    check("drop_req", 32'(a_slv_req), 32'd0);
    check("drop_gnt0", 32'(a_m0_gnt), 32'd0);
    check("drop_b_req", 32'(b_slv_req), 32'd0);
    cur = 103;
    drive(1'b1, 1'b1, 1'b0, A0, A1, 1'b1, 1'b0, 32'h0);
    check("relock_gnt0", 32'(a_m0_gnt), 32'd1);
    check("relock_addr", a_slv_addr, A0);
    check("relock_b_gnt0", 32'(b_m0_gnt), 32'd1);
    cur = 104;
    drive(1'b1, 1'b0, 1'b0, A0, A1, 1'b0, 1'b1, 32'h5555_0001);
    check("relock_rv0", 32'(a_m0_rv), 32'd1);
    check("relock_rd0", a_m0_rd, 32'h5555_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
